// File: rtl/fc_pkg.sv
// Shared types and helpers for the streaming fully-connected scorer.
package fc_pkg;

  // Controller states; ARGMAX is only reachable when FC_ARGMAX_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } fc_state_e;

  // Flat weight-store index: (k*num_ch + c)*num_pix + p.
  function automatic int unsigned wt_index(input int unsigned k,
                                           input int unsigned c,
                                           input int unsigned p,
                                           input int unsigned num_ch,
                                           input int unsigned num_pix);
    return (k * num_ch + c) * num_pix + p;
  endfunction

  // Signed product on 64-bit sign-extended operands; callers truncate to ACC_WIDTH.
  function automatic longint sext_mul(input longint a, input longint b);
    return a * b;
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Sequential signed max scanner: one class per cycle, ties keep the lowest index.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned NUM_CLASSES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [NUM_CLASSES*ACC_WIDTH-1:0]     scores,
  output logic                                 done_c,
  output logic [$clog2(NUM_CLASSES)-1:0]       class_idx
);

  localparam int unsigned CI_W = $clog2(NUM_CLASSES);

  logic                        busy;
  logic [CI_W-1:0]             cnt;
  logic signed [ACC_WIDTH-1:0] best;
  logic signed [ACC_WIDTH-1:0] cand;

  assign cand   = scores[32'(cnt) * ACC_WIDTH +: ACC_WIDTH];
  assign done_c = busy && (cnt == CI_W'(NUM_CLASSES - 1));

  // Scan register: first candidate always wins, later ones only when strictly greater.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      best      <= '0;
      class_idx <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if ((cnt == '0) || (cand > best)) begin
        best      <= cand;
        class_idx <= cnt;
      end
      if (done_c) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CI_W'(1);
      end
    end
  end

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: per-class dot product over NUM_PIX beats of
// NUM_CH channels, plus base and live bias. Optional argmax via FC_ARGMAX_EN.
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 20,
  parameter int unsigned W_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_PIX     = 169,
  parameter int unsigned NUM_CLASSES = 3
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic                                            in_sof,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                    in_data,
  input  logic [NUM_CLASSES*ACC_WIDTH-1:0]                adj_bias,
  input  logic                                            wt_we,
  input  logic [$clog2(NUM_CLASSES*NUM_CH*NUM_PIX)-1:0]   wt_addr,
  input  logic [W_WIDTH-1:0]                              wt_data,
  input  logic                                            bias_we,
  input  logic [$clog2(NUM_CLASSES)-1:0]                  bias_idx,
  input  logic [ACC_WIDTH-1:0]                            bias_data,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUM_CLASSES*ACC_WIDTH-1:0]                scores,
  output logic [$clog2(NUM_CLASSES)-1:0]                  class_idx,
  output logic                                            frame_err
);

  localparam int unsigned NUM_W = NUM_CLASSES * NUM_CH * NUM_PIX;
  localparam int unsigned WA_W  = $clog2(NUM_W);
  localparam int unsigned PC_W  = $clog2(NUM_PIX);

  fc_state_e                   state, state_next;
  logic [PC_W-1:0]             pix_cnt, pix_cnt_next;
  logic [PC_W-1:0]             pix_sel;
  logic signed [ACC_WIDTH-1:0] acc       [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] acc_next  [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] dot       [NUM_CLASSES];
  logic signed [ACC_WIDTH-1:0] base_bias [NUM_CLASSES];
  logic signed [W_WIDTH-1:0]   wt_mem    [NUM_W];
  logic beat, load_c, add_c, cap_c;
  logic in_ready_next, out_valid_next, frame_err_next;
  logic wt_wr;
`ifdef FC_ARGMAX_EN
  logic scan_done_c;
`endif

  assign beat  = in_valid && in_ready;
  assign wt_wr = wt_we && (state == IDLE) && (32'(wt_addr) < NUM_W);

  // Pixel whose weights the current beat uses: 0 on a (re)start, else the counter.
  assign pix_sel = ((state == ACCUM) && !in_sof) ? pix_cnt : '0;

  // Per-class dot product of this beat's channels against the selected weights.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      dot[k] = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        dot[k] = dot[k] + ACC_WIDTH'(sext_mul(
                   64'(signed'(in_data[c*DATA_WIDTH +: DATA_WIDTH])),
                   64'(wt_mem[WA_W'(wt_index(k, c, 32'(pix_sel), NUM_CH, NUM_PIX))])));
      end
    end
  end

  // Accumulator update: reload with biases on pixel 0, otherwise add; wraps freely.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      acc_next[k] = acc[k] + dot[k];
      if (load_c) begin
        acc_next[k] = base_bias[k] + ACC_WIDTH'(adj_bias[k*ACC_WIDTH +: ACC_WIDTH]) + dot[k];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    pix_cnt_next   = pix_cnt;
    load_c         = 1'b0;
    add_c          = 1'b0;
    cap_c          = 1'b0;
    frame_err_next = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          load_c       = 1'b1;
          pix_cnt_next = PC_W'(1);
          state_next   = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (in_sof) begin
            load_c         = 1'b1;
            pix_cnt_next   = PC_W'(1);
            frame_err_next = 1'b1;
          end else begin
            add_c = 1'b1;
            if (pix_cnt == PC_W'(NUM_PIX - 1)) begin
              cap_c        = 1'b1;
              pix_cnt_next = '0;
`ifdef FC_ARGMAX_EN
              state_next   = ARGMAX;
`else
              state_next   = DONE;
`endif
            end else begin
              pix_cnt_next = pix_cnt + PC_W'(1);
            end
          end
        end
      end
      ARGMAX: begin
`ifdef FC_ARGMAX_EN
        if (scan_done_c) begin
          state_next = DONE;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    in_ready_next  = (state_next == IDLE) || (state_next == ACCUM);
    out_valid_next = (state_next == DONE);
  end

  // State, counter, handshake outputs and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        acc[k] <= '0;
      end
    end else begin
      state     <= state_next;
      pix_cnt   <= pix_cnt_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      frame_err <= frame_err_next;
      if (load_c || add_c) begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
          acc[k] <= acc_next[k];
        end
      end
    end
  end

  // Score capture on the final pixel; held until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scores <= '0;
    end else if (cap_c) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        scores[k*ACC_WIDTH +: ACC_WIDTH] <= acc_next[k];
      end
    end
  end

  // Base bias registers, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        base_bias[k] <= '0;
      end
    end else if (bias_we && (state == IDLE)) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        if (32'(bias_idx) == k) begin
          base_bias[k] <= bias_data;
        end
      end
    end
  end

  // Weight store, not reset; in-range idle writes only.
  always_ff @(posedge clk) begin
    if (wt_wr) begin
      wt_mem[wt_addr] <= wt_data;
    end
  end

`ifdef FC_ARGMAX_EN
  fc_argmax #(
    .ACC_WIDTH   (ACC_WIDTH),
    .NUM_CLASSES (NUM_CLASSES)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (cap_c),
    .scores    (scores),
    .done_c    (scan_done_c),
    .class_idx (class_idx)
  );
`else
  assign class_idx = '0;
`endif

endmodule

// File: doc/fc_layer_stream.md
Name: fc_layer_stream

Overview:
- Parametrised successor to the fixed 3-class fully-connected scorer.
- Streams NUM_CH feature channels per pixel beat over a valid/ready handshake and accumulates one dot product per class against a runtime-loadable weight store plus bias.
- Presents all class scores with an output valid/ready handshake. Sits between the last pool stage and the classifier/UART reporting logic.

Parameters:
- DATA_WIDTH, 20, signed feature sample width
- W_WIDTH, 8, signed weight width
- ACC_WIDTH, 32, signed accumulator/score width
- NUM_CH, 4, channels delivered per beat
- NUM_PIX, 169, pixel beats per frame
- NUM_CLASSES, 3, output classes

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_sof  in  1  marks pixel 0 of a frame
- in_data  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH], signed
- adj_bias  in  NUM_CLASSES*ACC_WIDTH  live bias trim per class
- wt_we  in  1  weight write strobe
- wt_addr  in  clog2(NUM_CLASSES*NUM_CH*NUM_PIX)  addr = (k*NUM_CH + c)*NUM_PIX + p
- wt_data  in  W_WIDTH  signed weight
- bias_we  in  1  base-bias write strobe
- bias_idx  in  clog2(NUM_CLASSES)  class index
- bias_data  in  ACC_WIDTH  signed base bias
- out_valid  out  1  scores valid
- out_ready  in  1  consumer accepts
- scores  out  NUM_CLASSES*ACC_WIDTH  class k at [k*ACC_WIDTH +: ACC_WIDTH]
- class_idx  out  clog2(NUM_CLASSES)  winning class
- frame_err  out  1  one-cycle pulse on frame restart

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, scores=0, class_idx=0, frame_err=0, pixel counter 0, base biases 0. The weight store is not reset.
- States:
  - IDLE: first accepted beat is taken as pixel 0 whether or not in_sof is set. acc[k] = base_bias[k] + adj_bias[k] + sum over c of data[c]*W[k][c][0]. Counter = 1, go to ACCUM.
  - ACCUM: each accepted beat adds sum over c of data[c]*W[k][c][p]. When p = NUM_PIX-1 is accepted, go to DONE (or ARGMAX if the feature is enabled).
  - in_sof on an accepted beat in ACCUM restarts the frame: accumulator reloaded as in IDLE with this beat as pixel 0, frame_err pulses for one cycle.
  - DONE: in_ready=0, out_valid=1, scores and class_idx held stable. On out_valid&out_ready, go to IDLE; in_ready=1 the next cycle.
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Arithmetic: products sign-extended to ACC_WIDTH. Accumulation wraps in two's complement; there is no saturation.
- adj_bias is sampled only on pixel 0.
- Writes:
  - wt_we and bias_we take effect only in IDLE; writes in other states are dropped.
  - wt_addr beyond range is ignored.
  - A write and a pixel-0 beat in the same IDLE cycle: the beat uses the old value.
- in_valid low in ACCUM stalls with no change.
- Asynchronous reset mid-frame discards the partial frame.

Optional Feature:
- Macro FC_ARGMAX_EN.
- Defined:
  - ARGMAX state after the last beat scans classes one per cycle (NUM_CLASSES cycles) using signed compare, with ties going to the lowest index.
  - out_valid rises NUM_CLASSES+1 cycles after the last beat, with class_idx valid.
  - in_ready=0 during the scan.
- Undefined: no ARGMAX state and class_idx is held at 0.

Decomposition:
- Package fc_pkg holds:
  - state enum (IDLE, ACCUM, ARGMAX, DONE)
  - helper function for the flat weight address
  - ACC sign-extension helper
- One natural sub-module: fc_argmax, the sequential signed max scanner, instantiated only under FC_ARGMAX_EN.

Test Plan:
- Basic sum: all weights 1, biases 0, every channel sample 1 for 169 beats → each score 676 one cycle after the last beat; out_valid holds until out_ready.
- Bias path: base_bias = {-20, -32, 37}, adj_bias = {5, 0, -7}, all inputs 0 → scores {-15, -32, 30}. With FC_ARGMAX_EN, class_idx=2.
- Backpressure: out_ready=0 for 10 cycles → in_ready stays 0, scores stable; the next frame's first beat is accepted only after the handshake.
- Restart: in_sof asserted at beat 50 of a frame → frame_err pulses once; the result equals a clean 169-beat frame starting at that beat.
- Write lockout: wt_we during ACCUM setting W[0][0][5]=100 → no effect on the current or next frame's score; the same write in IDLE changes score0 by 100*data.
- Wrap and tie: with ACC_WIDTH=16, drive score0 past 32767 → it wraps to negative. Equal scores for classes 1 and 2 → class_idx=1.
